// File: rtl/wb_stage_regfile_if.sv
// rtl/wb_stage_regfile_if.sv - MEM/WB-side and decode-side signal bundle for wb_stage_regfile
//
// Purpose: groups the write-back request (from the MEM/WB register), the two
// decode read ports and the block's outputs into one interface.
// Modports:
//   slave  - used by wb_stage_regfile: takes WB_en, MEM_R_en, ALU_result,
//            MEM_read_value, Dest, src1, src2; drives reg1, reg2, wb_value,
//            wb_dest, wb_valid, retired_count.
//   master - the pipeline/decode side: the mirror image of slave.
interface wb_stage_regfile_if;
    logic        WB_en;
    logic        MEM_R_en;
    logic [31:0] ALU_result;
    logic [31:0] MEM_read_value;
    logic [3:0]  Dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] wb_value;
    logic [3:0]  wb_dest;
    logic        wb_valid;
    logic [31:0] retired_count;

    modport slave (
        input  WB_en, MEM_R_en, ALU_result, MEM_read_value, Dest, src1, src2,
        output reg1, reg2, wb_value, wb_dest, wb_valid, retired_count
    );

    modport master (
        output WB_en, MEM_R_en, ALU_result, MEM_read_value, Dest, src1, src2,
        input  reg1, reg2, wb_value, wb_dest, wb_valid, retired_count
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - write-back select, 16x32 register file with bypassed reads, retire counter
//
// Purpose: selects the retiring value (load data or ALU result), commits it to
// the architectural register file, serves two combinational decode read ports
// with same-cycle write-through bypass, and counts committed writes.
// Ports:
//   clk  - pipeline clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (clears file and counter)
//   bus  - wb_stage_regfile_if.slave: write-back request, read indices, outputs
module wb_stage_regfile (
    input  logic                  clk,
    input  logic                  rst,
    wb_stage_regfile_if.slave     bus
);

    logic [31:0] regs [16];
    logic [31:0] count_q;
    logic [31:0] wb_value_c;

    // Select does not look at WB_en so the forwarding network always sees a value.
    assign wb_value_c = bus.MEM_R_en ? bus.MEM_read_value : bus.ALU_result;

    assign bus.wb_value      = wb_value_c;
    assign bus.wb_dest       = bus.Dest;
    assign bus.wb_valid      = bus.WB_en;
    assign bus.retired_count = count_q;

    // Write-through bypass: a write retiring this cycle is visible to decode
    // in the same cycle, before it lands in the file.
    assign bus.reg1 = (bus.WB_en && (bus.Dest == bus.src1)) ? wb_value_c : regs[bus.src1];
    assign bus.reg2 = (bus.WB_en && (bus.Dest == bus.src2)) ? wb_value_c : regs[bus.src2];

    // Reset has priority: a write presented in a reset cycle is dropped and not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            count_q <= '0;
        end else if (bus.WB_en) begin
            regs[bus.Dest] <= wb_value_c;
            count_q        <= count_q + 32'd1;
        end
    end

endmodule

// File: doc/wb_stage_regfile.md
# wb_stage_regfile

Write-back stage plus architectural register file for the 5-stage pipeline. It sits at the far end of the MEM/WB pipeline register and consumes that register's outputs. Each cycle it selects the value to retire (memory load data or ALU result) and commits it to a 16 x 32 register file. It also serves two decode-stage read ports with same-cycle write-through bypass and keeps a count of retired register writes.

## Interface
Parameters:
- none; widths fixed: data 32 bits, register index 4 bits, 16 registers.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- WB_en  input  1  from MEM/WB register; retire a register write this cycle.
- MEM_R_en  input  1  from MEM/WB register; 1 selects MEM_read_value, 0 selects ALU_result.
- ALU_result  input  32  from MEM/WB register.
- MEM_read_value  input  32  from MEM/WB register.
- Dest  input  4  from MEM/WB register; destination register index.
- src1  input  4  decode read port 1 index.
- src2  input  4  decode read port 2 index.
- reg1  output  32  read data, port 1 (combinational, bypassed).
- reg2  output  32  read data, port 2 (combinational, bypassed).
- wb_value  output  32  selected write-back value (combinational); also feeds the forwarding network.
- wb_dest  output  4  equals Dest (combinational).
- wb_valid  output  1  equals WB_en (combinational).
- retired_count  output  32  registered count of committed writes.

## Operation
- Select: wb_value = MEM_R_en ? MEM_read_value : ALU_result. Select is independent of WB_en.
- Commit: on a rising edge with rst=0 and WB_en=1, regs[Dest] <= wb_value. With WB_en=0, the file holds.
- All 16 indices, including 15, are ordinary writable storage. This block applies no PC special-casing.
- Read port n:
  - If WB_en=1 and Dest==srcn, regN = wb_value (write-through bypass).
  - Otherwise regN = regs[srcn].
  - The two ports are fully independent. Both may hit the bypass in the same cycle.
- Counter: on a rising edge with rst=0 and WB_en=1, retired_count <= retired_count + 1, modulo 2^32. 0xFFFFFFFF wraps to 0 with no flag.
- Reset: on a rising edge with rst=1, all 16 registers <= 0 and retired_count <= 0. Reset wins over a simultaneous WB_en=1, so no write and no increment occur. Reset arriving mid-sequence discards any write presented in that cycle.
- No internal state machine beyond the file and the counter. The block never stalls and has no back-pressure; one write is accepted every cycle.

## Timing
- Reset values: all regs 0; retired_count 0. reg1, reg2, wb_value, wb_dest and wb_valid are combinational, so after reset they reflect the current inputs and zeroed storage.
- Write latency: a value presented with WB_en=1 in cycle N is:
  - visible through the bypass in cycle N;
  - stored and readable without bypass from cycle N+1.
- retired_count reflects cycle-N writes from cycle N+1.
- Combinational path src/Dest/WB_en/MEM_R_en/data -> reg1/reg2 must fit within one cycle alongside decode. No registered read.
- Back-to-back writes to the same Dest in consecutive cycles: the last one wins. Each intermediate value is readable via bypass only in its own cycle.

## Test plan
- Reset then read: assert rst for 1 cycle with WB_en=1, Dest=3, ALU_result=0xDEADBEEF. Then src1=3 with WB_en=0 -> reg1=0, retired_count=0.
- ALU write-back: WB_en=1, MEM_R_en=0, Dest=5, ALU_result=0x12345678, MEM_read_value=0xFFFFFFFF. Same cycle src1=5 -> reg1=0x12345678 (bypass). Next cycle, WB_en=0 -> reg1=0x12345678, retired_count=1.
- Load write-back: WB_en=1, MEM_R_en=1, Dest=15, MEM_read_value=0xCAFEF00D. Next cycle src2=15 -> reg2=0xCAFEF00D.
- Dual bypass and disabled write: WB_en=1, Dest=7, value 0xA5A5A5A5, src1=src2=7 -> reg1=reg2=0xA5A5A5A5. Then WB_en=0, Dest=7, value 0x1 -> reg7 stays 0xA5A5A5A5 and no bypass occurs.
- Back-to-back same destination: Dest=2 with values 0x11, 0x22, 0x33 in consecutive cycles -> src1=2 shows 0x11/0x22/0x33 via bypass each cycle, holds 0x33 afterwards, retired_count=3.
- Counter wrap: after 2^32-1 writes (or a forced counter value) retired_count=0xFFFFFFFF. One more WB_en=1 -> 0x00000000.
